// File: rtl/hvtx_pattern.sv
// hvtx_pattern: test-pattern generator with bouncing box, registered RGB out
module hvtx_pattern #(
  parameter int WIDTH = 11,
  parameter int ACTIVE_WIDTH = 1280,
  parameter int ACTIVE_HEIGHT = 720,
  parameter int BOX_SIZE = 16,
  parameter int STEP = 4,
  parameter int FRAME_DIV = 1,
  parameter int CHECK_LOG2 = 5,
  parameter logic [23:0] BOX_COLOR = 24'hff00a8,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic [1:0]       i_mode,
  input  logic             i_freeze,
  output logic [23:0]      o_video,
  output logic             o_tick
);
  localparam int DW = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam int BAR_W = ACTIVE_WIDTH / 8;
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(ACTIVE_WIDTH - BOX_SIZE);
  localparam logic [WIDTH:0] MAX_Y = (WIDTH+1)'(ACTIVE_HEIGHT - BOX_SIZE);
  localparam logic [23:0] BARS [8] = '{24'hffffff, 24'hffff00, 24'h00ffff, 24'h00ff00,
                                       24'hff00ff, 24'hff0000, 24'h0000ff, 24'h000000};
  logic [1:0]       mode_q, mode_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [23:0]      video_d, bg;
  logic [WIDTH:0]   nx, ny;
  logic [2:0]       bar;
  logic             tick, upd, active, hit;
  // returns {new_dir, new_pos}; dir 1 means moving toward larger coordinates
  function automatic logic [WIDTH:0] nxt(input logic [WIDTH-1:0] p, input logic d,
                                         input logic [WIDTH:0] mx);
    logic [WIDTH:0] s;
    s = {1'b0, p} + (WIDTH+1)'(STEP);
    if (d) nxt = (s >= mx) ? {1'b0, mx[WIDTH-1:0]} : {1'b1, s[WIDTH-1:0]};
    else   nxt = ({1'b0, p} <= (WIDTH+1)'(STEP)) ? {1'b1, {WIDTH{1'b0}}}
                                                 : {1'b0, p - WIDTH'(STEP)};
  endfunction
  assign tick = (i_x == '0) && (i_y == WIDTH'(ACTIVE_HEIGHT));
  assign upd = tick && (div_q == DW'(FRAME_DIV - 1)) && !i_freeze;
  assign nx = nxt(box_x_q, dir_x_q, MAX_X);
  assign ny = nxt(box_y_q, dir_y_q, MAX_Y);
  assign active = (i_x < WIDTH'(ACTIVE_WIDTH)) && (i_y < WIDTH'(ACTIVE_HEIGHT));
  assign hit = ({1'b0, i_x} >= {1'b0, box_x_q}) && ({1'b0, i_x} < {1'b0, box_x_q} + (WIDTH+1)'(BOX_SIZE))
            && ({1'b0, i_y} >= {1'b0, box_y_q}) && ({1'b0, i_y} < {1'b0, box_y_q} + (WIDTH+1)'(BOX_SIZE));
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) bar = bar + 3'({1'b0, i_x} >= (WIDTH+1)'(k * BAR_W));
  end
  always_comb begin
    mode_d = tick ? i_mode : mode_q;
    div_d = !tick ? div_q : (div_q == DW'(FRAME_DIV - 1)) ? '0 : div_q + 1'b1;
    box_x_d = upd ? nx[WIDTH-1:0] : box_x_q;
    dir_x_d = upd ? nx[WIDTH] : dir_x_q;
    box_y_d = upd ? ny[WIDTH-1:0] : box_y_q;
    dir_y_d = upd ? ny[WIDTH] : dir_y_q;
    bg = mode_q == 2'd0 ? BG_COLOR
       : mode_q == 2'd2 ? ((i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2]) ? 24'hffffff : BG_COLOR)
       : BARS[bar];
    video_d = !active ? 24'h000000 : (mode_q != 2'd1 && hit) ? BOX_COLOR : bg;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q  <= '0;
      div_q   <= '0;
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      o_video <= '0;
      o_tick  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      o_video <= video_d;
      o_tick  <= tick;
    end
  end
endmodule

// File: tb/tb_hvtx_pattern.sv
// tb_hvtx_pattern: directed bench for hvtx_pattern (default and FRAME_DIV=3 instances)
module tb_hvtx_pattern;
  localparam logic [23:0] BOX = 24'hff00a8;
  logic clk = 0, rst_n = 0, freeze = 0;
  logic [10:0] x = 0, y = 0;
  logic [1:0] mode = 0;
  logic [23:0] v, v3;
  logic t, t3;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  hvtx_pattern dut (.i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_mode(mode),
                    .i_freeze(freeze), .o_video(v), .o_tick(t));
  hvtx_pattern #(.FRAME_DIV(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_mode(mode),
                    .i_freeze(freeze), .o_video(v3), .o_tick(t3));
  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic pix(input int px, input int py);
    @(negedge clk);
    x = 11'(px);
    y = 11'(py);
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    pix(0, 720);
    chk("tick_hi", {23'd0, t}, 24'd1);
    chk("tick_blank", v, 24'h0);
    pix(1, 720);
    chk("tick_lo", {23'd0, t}, 24'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_video", v, 24'h0);
    chk("rst_tick", {23'd0, t}, 24'd0);
    @(negedge clk) rst_n = 1;
    pix(0, 0);
    chk("m0_origin", v, BOX);
    chk("d3_origin", v3, BOX);
    @(negedge clk);
    x = 16;
    #1;
    chk("latency_hold", v, BOX);
    @(posedge clk);
    #1;
    chk("m0_x16", v, 24'h0);
    pix(15, 15);
    chk("m0_corner", v, BOX);
    pix(1280, 0);
    chk("m0_outside", v, 24'h0);
    tick();
    pix(4, 4);   chk("t1_box", v, BOX);
    pix(3, 4);   chk("t1_left", v, 24'h0);
    pix(4, 3);   chk("t1_above", v, 24'h0);
    pix(0, 0);   chk("d3_t1_hold", v3, BOX);
    tick();
    pix(8, 8);   chk("t2_box", v, BOX);
    tick();
    pix(12, 12); chk("t3_box", v, BOX);
    pix(11, 12); chk("t3_left", v, 24'h0);
    pix(4, 4);   chk("d3_t3_box", v3, BOX);
    pix(3, 4);   chk("d3_t3_left", v3, 24'h0);
    freeze = 1;
    repeat (5) tick();
    freeze = 0;
    pix(12, 12); chk("frz_box", v, BOX);
    pix(4, 4);   chk("d3_frz_box", v3, BOX);
    tick();
    pix(16, 16); chk("t9_box", v, BOX);
    pix(15, 16); chk("t9_left", v, 24'h0);
    pix(8, 8);   chk("d3_div_adv", v3, BOX);
    pix(7, 8);   chk("d3_div_left", v3, 24'h0);
    pix(0, 200);
    mode = 3;
    pix(100, 300); chk("midframe_m0", v, 24'h0);
    tick();
    pix(159, 0);  chk("bar0_end", v, 24'hffffff);
    pix(160, 0);  chk("bar1_start", v, 24'hffff00);
    pix(640, 5);  chk("bar4", v, 24'hff00ff);
    pix(1279, 0); chk("bar7_last", v, 24'h000000);
    pix(20, 20);  chk("m3_box", v, BOX);
    mode = 1;
    tick();
    pix(24, 24);  chk("m1_nobox", v, 24'hffffff);
    pix(960, 0);  chk("bar6", v, 24'h0000ff);
    mode = 2;
    tick();
    pix(31, 0);   chk("chk_31_0", v, 24'h0);
    pix(32, 0);   chk("chk_32_0", v, 24'hffffff);
    pix(96, 32);  chk("chk_96_32", v, 24'h0);
    pix(28, 28);  chk("m2_box", v, BOX);
    mode = 0;
    repeat (168) tick();
    pix(700, 700); chk("y700_box", v, BOX);
    tick();
    pix(704, 704); chk("y704_box", v, BOX);
    pix(704, 703); chk("y704_above", v, 24'h0);
    tick();
    pix(708, 700); chk("y700_back", v, BOX);
    pix(708, 699); chk("y700_above", v, 24'h0);
    repeat (138) tick();
    pix(1260, 148); chk("x1260_box", v, BOX);
    tick();
    pix(1264, 144); chk("x1264_box", v, BOX);
    pix(1263, 144); chk("x1264_left", v, 24'h0);
    pix(1279, 159); chk("x1264_corner", v, BOX);
    tick();
    pix(1260, 140); chk("x1260_back", v, BOX);
    pix(1276, 140); chk("x1260_right", v, 24'h0);
    pix(1260, 140);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst", v, 24'h0);
    @(negedge clk) rst_n = 1;
    pix(0, 0);      chk("rst_origin", v, BOX);
    pix(1260, 140); chk("rst_old_pos", v, 24'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
